imm_gen_pipe: RTL and testbench

//  Parametrised, buffered RISC-V immediate generator between decode and execute.
//  - Accepts a 32-bit instruction word plus a format code over a valid/ready handshake.
//  - Produces the sign-extended XLEN-bit immediate from a DEPTH-entry in-order FIFO.
//  - Covers R/I/S/B/U/J formats and reports illegal format codes.
//  - Has no combinational path from input to output.

---
 rtl/imm_gen_pipe.sv | 122 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: buffered RISC-V immediate generator between decode and execute.
// The immediate is decoded on the push side and stored as {imm, err}. As a result,
// the outputs come only from registered FIFO state, with no combinational input->output path.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous discard of all buffered entries (wins over push/pop)
//   in_valid/ready  producer handshake; in_ready = !full
//   in_instr/fmt    32-bit instruction word, format code (0=R 1=I 2=S 3=B 4=U 5=J 6=Z 7=rsvd)
//   out_valid/ready consumer handshake; out_valid = !empty
//   out_imm/err     head entry immediate and illegal-format flag (0 when empty)
//   count           FIFO occupancy
//
// Build option: define IMMGEN_ZIMM_EN to make fmt 6 (CSR zimm, zero-extended
// instr[19:15]) legal. Without it, fmt 6 is reported as illegal.

module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [2:0]               in_fmt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = XLEN + 1;

    // Elaboration-time parameter guards
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] imm_c;
    logic            err_c;
    logic            sgn;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   mem [DEPTH];

    // Opcode bits never contribute to any immediate
    logic            unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    assign sgn = in_instr[31];

    // Immediate decode on the push side
    always_comb begin
        imm_c = '0;
        err_c = 1'b0;
        case (in_fmt)
            3'd0: imm_c = '0;
            3'd1: imm_c = {{(XLEN-12){sgn}}, in_instr[31:20]};
            3'd2: imm_c = {{(XLEN-12){sgn}}, in_instr[31:25], in_instr[11:7]};
            3'd3: imm_c = {{(XLEN-12){sgn}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            3'd4: imm_c = {{(XLEN-31){sgn}}, in_instr[30:12], 12'b0};
            3'd5: imm_c = {{(XLEN-20){sgn}}, in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
`ifdef IMMGEN_ZIMM_EN
            3'd6: imm_c = {{(XLEN-5){1'b0}}, in_instr[19:15]};
`endif
            default: err_c = 1'b1;
        endcase
    end

    // Ready and valid come from count only, so a full FIFO refuses a push even while popping
    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm   = out_valid ? mem[rd_ptr][EW-1:1] : '0;
    assign out_err   = out_valid ? mem[rd_ptr][0]      : 1'b0;

    // Storage: payload only, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {imm_c, err_c};
        end
    end

    // Pointers and occupancy; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Instance a is XLEN=32/DEPTH=2, and instance b is XLEN=64/DEPTH=4.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [31:0] a_in_instr;
    logic [2:0]  a_in_fmt;
    logic [31:0] a_out_imm;
    logic [1:0]  a_count;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [31:0] b_in_instr;
    logic [2:0]  b_in_fmt;
    logic [63:0] b_out_imm;
    logic [2:0]  b_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_fmt(a_in_fmt),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_err(a_out_err), .count(a_count)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_fmt(b_in_fmt),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_err(b_out_err), .count(b_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [31:0] instr, input logic [2:0] fmt);
        a_in_valid = 1'b1;
        a_in_instr = instr;
        a_in_fmt   = fmt;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic a_pop();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic b_push(input logic [31:0] instr, input logic [2:0] fmt);
        b_in_valid = 1'b1;
        b_in_instr = instr;
        b_in_fmt   = fmt;
        tick();
        b_in_valid = 1'b0;
    endtask

    task automatic b_pop();
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    // Push one word into the 32-bit instance, check its head, then drain it
    task automatic a_case(input string tag, input logic [31:0] instr, input logic [2:0] fmt,
                          input logic [31:0] exp_imm, input logic exp_err);
        a_push(instr, fmt);
        check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
        check({tag, "_imm"},   64'(a_out_imm),   64'(exp_imm));
        check({tag, "_err"},   64'(a_out_err),   64'(exp_err));
        a_pop();
        check({tag, "_empty"}, 64'(a_out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] zimm_exp;
        logic        zerr_exp;

        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_instr = '0; a_in_fmt = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_instr = '0; b_in_fmt = '0;

        // Reset state, observed while rst is still asserted
        #1;
        check("rst_in_ready",  64'(a_in_ready),  64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_count",     64'(a_count),     64'd0);
        check("rst_out_imm",   64'(a_out_imm),   64'd0);
        check("rst_out_err",   64'(a_out_err),   64'd0);
        check("rst_b_ready",   64'(b_in_ready),  64'd1);
        tick();
        tick();
        rst = 1'b0;
        #2;
        check("post_rst_ready", 64'(a_in_ready), 64'd1);

        // I-type, including one-cycle latency
        a_in_valid = 1'b1; a_in_instr = 32'hFFF0_0093; a_in_fmt = 3'd1;
        check("i_pre_valid", 64'(a_out_valid), 64'd0);
        tick();
        a_in_valid = 1'b0;
        check("i_valid", 64'(a_out_valid), 64'd1);
        check("i_imm",   64'(a_out_imm),   64'h0000_0000_FFFF_FFFF);
        check("i_err",   64'(a_out_err),   64'd0);
        check("i_count", 64'(a_count),     64'd1);
        a_pop();
        check("i_empty",     64'(a_out_valid), 64'd0);
        check("i_empty_imm", 64'(a_out_imm),   64'd0);

        // Other formats
        a_case("b",  32'hFE00_0EE3, 3'd3, 32'hFFFF_FFFC, 1'b0);
        a_case("j",  32'h0010_006F, 3'd5, 32'h0000_0800, 1'b0);
        a_case("s",  32'h0011_2223, 3'd2, 32'h0000_0004, 1'b0);
        a_case("r",  32'hFFFF_FFB3, 3'd0, 32'h0000_0000, 1'b0);
`ifdef IMMGEN_ZIMM_EN
        zimm_exp = 32'h0000_001F; zerr_exp = 1'b0;
`else
        zimm_exp = 32'h0000_0000; zerr_exp = 1'b1;
`endif
        a_case("z",    32'h000F_D073, 3'd6, zimm_exp, zerr_exp);
        a_case("rsvd", 32'hFFF0_0093, 3'd7, 32'h0000_0000, 1'b1);

        // XLEN=64 U-type sign extension, in order through the FIFO
        b_push(32'h8000_0037, 3'd4);
        b_push(32'h1234_50B7, 3'd4);
        check("u64_count", 64'(b_count),   64'd2);
        check("u64_neg",   b_out_imm,      64'hFFFF_FFFF_8000_0000);
        check("u64_err",   64'(b_out_err), 64'd0);
        b_pop();
        check("u64_pos",   b_out_imm,      64'h0000_0000_1234_5000);
        b_pop();
        check("u64_empty", 64'(b_out_valid), 64'd0);

        // Backpressure on DEPTH=2: A, B accepted, C held until space frees
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_fmt = 3'd1;
        a_in_instr = 32'h0010_0013;
        tick();
        a_in_instr = 32'h0020_0013;
        tick();
        check("bp_full_count", 64'(a_count),    64'd2);
        check("bp_full_ready", 64'(a_in_ready), 64'd0);
        check("bp_head_a",     64'(a_out_imm),  64'd1);
        a_in_instr = 32'h0030_0013;
        tick();
        check("bp_held_count", 64'(a_count),    64'd2);
        check("bp_held_ready", 64'(a_in_ready), 64'd0);
        check("bp_held_head",  64'(a_out_imm),  64'd1);
        a_out_ready = 1'b1;
        tick();
        check("bp_pop1_count", 64'(a_count),    64'd1);
        check("bp_pop1_ready", 64'(a_in_ready), 64'd1);
        check("bp_head_b",     64'(a_out_imm),  64'd2);
        tick();
        check("bp_pushpop_count", 64'(a_count),   64'd1);
        check("bp_head_c",        64'(a_out_imm), 64'd3);
        a_in_valid = 1'b0;
        tick();
        check("bp_drained", 64'(a_count),     64'd0);
        check("bp_novalid", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b0;

        // Flush wins over a simultaneous push (DEPTH=4 instance has room)
        b_push(32'h0050_0013, 3'd1);
        b_push(32'h0060_0013, 3'd1);
        check("fl_pre_count", 64'(b_count), 64'd2);
        b_flush = 1'b1; b_in_valid = 1'b1; b_in_instr = 32'h0070_0013; b_in_fmt = 3'd1;
        tick();
        b_flush = 1'b0; b_in_valid = 1'b0;
        check("fl_count", 64'(b_count),     64'd0);
        check("fl_valid", 64'(b_out_valid), 64'd0);
        check("fl_imm",   b_out_imm,        64'd0);
        tick();
        check("fl_discard", 64'(b_count), 64'd0);

        // Flush wins over push and pop together on the DEPTH=2 instance
        a_push(32'h0080_0013, 3'd1);
        a_flush = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_instr = 32'h0090_0013;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("fl_a_count", 64'(a_count), 64'd0);

        // Asynchronous reset mid-stream clears outputs before any edge
        a_push(32'h0010_0013, 3'd1);
        check("ar_pre_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 64'(a_out_valid), 64'd0);
        check("ar_imm",   64'(a_out_imm),   64'd0);
        check("ar_err",   64'(a_out_err),   64'd0);
        check("ar_count", 64'(a_count),     64'd0);
        check("ar_ready", 64'(a_in_ready),  64'd1);
        #2;
        rst = 1'b0;
        tick();

        // Normal operation after reset
        a_case("post_ar", 32'h8000_0013, 3'd1, 32'hFFFF_F800, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
